// File: rtl/row_window_buffer.sv
// Row window buffer: buffers KERNEL_SIZE-1 raster rows in circular line memories and emits one
// vertical column per accepted pixel, oldest row in slice 0. Optional ZERO_PAD_EN: emit from row 0 with zero rows above the frame.
//
// state | meaning
// IDLE  | waiting for start, config latched on accepted start
// FILL  | first KERNEL_SIZE-1 rows written, no columns emitted
// RUN   | one column emitted per accepted pixel
// DRAIN | all pixels accepted, waiting for final column handoff
module row_window_buffer #(
  parameter int PIXEL_BITS  = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int MAX_WIDTH   = 512,
  parameter int MAX_HEIGHT  = 512
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]      cfg_width,
  input  logic [$clog2(MAX_HEIGHT+1)-1:0]     cfg_height,
  input  logic [PIXEL_BITS-1:0]               in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [PIXEL_BITS*KERNEL_SIZE-1:0]   out_column,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                cfg_err
);
  localparam int RB_COUNT = KERNEL_SIZE - 1;
  localparam int CW = $clog2(MAX_WIDTH + 1);
  localparam int HW = $clog2(MAX_HEIGHT + 1);
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int SW = (RB_COUNT > 1) ? $clog2(RB_COUNT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;
`ifdef ZERO_PAD_EN
  localparam logic [1:0] ST_FIRST = ST_RUN;
`else
  localparam logic [1:0] ST_FIRST = ST_FILL;
`endif

  localparam logic [CW-1:0] C_W_ONE = CW'(1);
  localparam logic [CW-1:0] C_W_MIN = CW'(2);
  localparam logic [CW-1:0] C_W_MAX = CW'(MAX_WIDTH);
  localparam logic [HW-1:0] C_H_ONE = HW'(1);
  localparam logic [HW-1:0] C_H_MIN = HW'(KERNEL_SIZE);
  localparam logic [HW-1:0] C_H_MAX = HW'(MAX_HEIGHT);
  localparam logic [HW-1:0] C_H_FILL_END = HW'(RB_COUNT - 1);
  localparam logic [SW-1:0] C_SLOT_LAST  = SW'(RB_COUNT - 1);

  logic [1:0]            r_state;
  logic [CW-1:0]         r_width;
  logic [HW-1:0]         r_height;
  logic [CW-1:0]         r_col;
  logic [HW-1:0]         r_row;
  logic [SW-1:0]         r_slot;
  logic [SW-1:0]         r_rot_slot;
  logic [PIXEL_BITS-1:0] r_pix;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  r_cfg_err;
`ifdef ZERO_PAD_EN
  logic [HW-1:0]         r_out_row;
`endif

  logic                  w_cfg_ok;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_emit;
  logic                  w_hs;
  logic                  w_row_end;
  logic                  w_last_row;
  logic [AW-1:0]         w_addr;
  logic [PIXEL_BITS-1:0] w_rd [RB_COUNT];
  logic [PIXEL_BITS*KERNEL_SIZE-1:0] w_column;

  assign w_cfg_ok   = (cfg_width >= C_W_MIN) && (cfg_width <= C_W_MAX) &&
                      (cfg_height >= C_H_MIN) && (cfg_height <= C_H_MAX);
  assign w_in_ready = (r_state == ST_FILL) || ((r_state == ST_RUN) && (!r_out_valid || out_ready));
  assign w_accept   = in_valid && w_in_ready;
  assign w_emit     = w_accept && (r_state == ST_RUN);
  assign w_hs       = r_out_valid && out_ready;
  assign w_row_end  = (r_col == r_width - C_W_ONE);
  assign w_last_row = (r_row == r_height - C_H_ONE);
  assign w_addr     = r_col[AW-1:0];

  // Read-first line memories: read data register only moves on accept, so stalls hold the column.
  for (genvar g = 0; g < RB_COUNT; g++) begin : g_line
    logic [PIXEL_BITS-1:0] r_mem [MAX_WIDTH];
    logic [PIXEL_BITS-1:0] r_rd;
    always_ff @(posedge clk) begin
      if (w_accept) begin
        r_rd <= r_mem[w_addr];
        if (r_slot == SW'(g)) r_mem[w_addr] <= in_data;
      end
    end
    assign w_rd[g] = r_rd;
  end

  always_comb begin
    w_column = '0;
    for (int k = 0; k < RB_COUNT; k++) begin
      int idx;
      idx = int'(r_rot_slot) + k;
      if (idx >= RB_COUNT) idx = idx - RB_COUNT;
      w_column[k*PIXEL_BITS +: PIXEL_BITS] = w_rd[SW'(idx)];
`ifdef ZERO_PAD_EN
      if (k + int'(r_out_row) < RB_COUNT) w_column[k*PIXEL_BITS +: PIXEL_BITS] = '0;
`endif
    end
    w_column[RB_COUNT*PIXEL_BITS +: PIXEL_BITS] = r_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_width      <= '0;
      r_height     <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_slot       <= '0;
      r_rot_slot   <= '0;
      r_pix        <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
`ifdef ZERO_PAD_EN
      r_out_row    <= '0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
      if (w_accept) begin
        r_pix      <= in_data;
        r_rot_slot <= r_slot;
`ifdef ZERO_PAD_EN
        r_out_row  <= r_row;
`endif
        if (w_row_end) begin
          r_col  <= '0;
          r_row  <= r_row + C_H_ONE;
          r_slot <= (r_slot == C_SLOT_LAST) ? '0 : r_slot + SW'(1);
        end else begin
          r_col <= r_col + C_W_ONE;
        end
      end
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_last  <= w_row_end && w_last_row;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_width  <= cfg_width;
              r_height <= cfg_height;
              r_col    <= '0;
              r_row    <= '0;
              r_slot   <= '0;
              r_busy   <= 1'b1;
              r_state  <= ST_FIRST;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_FILL: if (w_accept && w_row_end && (r_row == C_H_FILL_END)) r_state <= ST_RUN;
        ST_RUN:  if (w_accept && w_row_end && w_last_row) r_state <= ST_DRAIN;
        default: begin
          if (w_hs) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_column = r_out_valid ? w_column : '0;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign cfg_err    = r_cfg_err;
endmodule

// File: tb/tb_row_window_buffer.sv
// Directed bench for row_window_buffer with KERNEL_SIZE=3, 8-bit pixels, 16x16 max frame.
// Expectations follow the macro ZERO_PAD_EN when the bench is built with it.
module tb_row_window_buffer;
  localparam int PB = 8;
  localparam int K = 3;
  localparam int MW = 16;
  localparam int MH = 16;
`ifdef ZERO_PAD_EN
  localparam int FIRST_ROW = 0;
  localparam logic [23:0] EXP_FIRST = 24'h010000;
  localparam logic [23:0] EXP_FIFTH = 24'h050100;
`else
  localparam int FIRST_ROW = K - 1;
  localparam logic [23:0] EXP_FIRST = 24'h090501;
  localparam logic [23:0] EXP_FIFTH = 24'h0d0905;
`endif
  localparam logic [23:0] EXP_LAST = 24'h100c08;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  cfg_width = '0;
  logic [4:0]  cfg_height = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] out_column;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        frame_done;
  logic        cfg_err;

  int total = 0;
  int bad = 0;
  logic [23:0] c_first, c_fifth, c_last;

  row_window_buffer #(.PIXEL_BITS(PB), .KERNEL_SIZE(K), .MAX_WIDTH(MW), .MAX_HEIGHT(MH)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_column(out_column), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pv(input int base, input int w, input int y, input int x);
    if (y < 0) return 8'd0;
    return 8'(base + y * w + x + 1);
  endfunction

  function automatic logic [23:0] exp_col(input int base, input int w, input int idx);
    int y, x;
    y = FIRST_ROW + idx / w;
    x = idx % w;
    return {pv(base, w, y, x), pv(base, w, y - 1, x), pv(base, w, y - 2, x)};
  endfunction

  // Called at a falling edge with the block idle; returns at a falling edge.
  task automatic do_start(input int w, input int h);
    cfg_width = 5'(w);
    cfg_height = 5'(h);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic bad_start(input string tag, input int w, input int h);
    cfg_width = 5'(w);
    cfg_height = 5'(h);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check({tag, "_err"}, cfg_err, 1);
    check({tag, "_busy"}, busy, 0);
    @(posedge clk); @(negedge clk);
    check({tag, "_err_pulse"}, cfg_err, 0);
    check({tag, "_busy2"}, busy, 0);
  endtask

  // Streams one frame; optional 3-cycle stall at column stall_idx; stops early after rst_after pixels.
  task automatic run_frame(input int w, input int h, input int base, input int stall_idx, input int rst_after);
    int n_exp, got, pix, stall, acc_first, first_v, first_hs, last_hs, fd;
    n_exp = w * (h - FIRST_ROW);
    got = 0; pix = 0; stall = 0;
    acc_first = -1; first_v = -1; first_hs = -1; last_hs = -1; fd = -1;
    for (int c = 0; c < 2000; c++) begin
      in_valid = (pix < w * h);
      in_data = pv(base, w, pix / w, pix % w);
      out_ready = !(out_valid && got == stall_idx && stall < 3);
      #1;
      if (out_valid && first_v < 0) first_v = c;
      if (!out_ready) begin
        stall++;
        check("stall_hold", out_column, exp_col(base, w, got));
        check("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        check("column", out_column, exp_col(base, w, got));
        check("out_last", out_last, (got == n_exp - 1));
        if (got == 0) begin c_first = out_column; first_hs = c; end
        if (got == 4) c_fifth = out_column;
        c_last = out_column;
        last_hs = c;
        got++;
      end
      if (in_valid && in_ready) begin
        if (pix == FIRST_ROW * w) acc_first = c;
        pix++;
      end
      if (rst_after > 0 && pix == rst_after) break;
      if (frame_done) begin fd = c; break; end
      @(posedge clk); @(negedge clk);
    end
    if (rst_after <= 0) begin
      check("frame_done_seen", (fd >= 0), 1);
      check("column_count", got, n_exp);
      check("first_latency", first_v - acc_first, 1);
      check("frame_done_latency", fd - last_hs, 1);
      check("busy_at_done", busy, 0);
      check("pixel_count", pix, w * h);
      if (stall_idx < 0) check("throughput", last_hs - first_hs, n_exp - 1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_column", out_column, 0);
    check("rst_last", out_last, 0);
    rst = 1'b0;
    @(negedge clk);

    // 4x4 frame, free flowing
    do_start(4, 4);
    run_frame(4, 4, 0, -1, 0);
    check("t1_first", c_first, EXP_FIRST);
    check("t1_fifth", c_fifth, EXP_FIFTH);
    check("t1_last", c_last, EXP_LAST);

    // backpressure on the second column
    do_start(4, 4);
    run_frame(4, 4, 0, 1, 0);
    check("t3_first", c_first, EXP_FIRST);
    check("t3_last", c_last, EXP_LAST);

    // rejected configurations
    bad_start("w0", 0, 4);
    bad_start("wmax1", MW + 1, 4);
    bad_start("h2", 4, 2);

    // reset mid-frame, then a clean frame
    do_start(4, 4);
    run_frame(4, 4, 0, -1, 11);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_column", out_column, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", frame_done, 0);
    check("mid_rst_err", cfg_err, 0);
    check("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    do_start(4, 4);
    run_frame(4, 4, 0, -1, 0);
    check("t5_first", c_first, EXP_FIRST);
    check("t5_last", c_last, EXP_LAST);

    // back-to-back full-width frames, restarted in the frame_done cycle
    do_start(MW, 5);
    run_frame(MW, 5, 0, -1, 0);
    do_start(MW, 5);
    run_frame(MW, 5, 120, -1, 0);
    check("t6_last", c_last, exp_col(120, MW, MW * (5 - FIRST_ROW) - 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
